// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM states, line
// encodings and the default baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_OFF  = 2'b11
  } parity_t;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_t;

  function automatic int default_div(input int clk_fre, input int baud_rate);
    longint clocks;
    clocks = longint'(clk_fre) * longint'(1000000);
    return int'(clocks / longint'(baud_rate));
  endfunction

  function automatic logic [7:0] data_mask(input data_bits_t bits);
    case (bits)
      BITS_5:  return 8'h1F;
      BITS_6:  return 8'h3F;
      BITS_7:  return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Index of the final data bit: 4 for five bits up to 7 for eight.
  function automatic logic [2:0] last_bit_idx(input data_bits_t bits);
    return {1'b0, bits} + 3'd4;
  endfunction

  function automatic logic parity_enabled(input parity_t par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // A push and pop on the same edge leave the level untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter with run-time frame format and baud divisor,
// both captured per frame when the byte leaves the FIFO.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 27,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(default_div(CLK_FRE, BAUD_RATE));

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_bit_q, par_bit_d;
  data_bits_t       nbits_q, nbits_d;
  parity_t          par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             pin_q, pin_d;

  logic             load_frame;
  logic             bit_end;
  logic             fifo_empty;
  logic             fifo_full;
  logic [7:0]       fifo_head;
  logic [DIV_W-1:0] eff_div;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_data_valid),
    .wr_data (tx_data),
    .rd_en   (load_frame),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_data_ready = !fifo_full;
  assign eff_div       = (cfg_div == '0) ? DEFAULT_DIV : cfg_div;
  assign bit_end       = (cnt_q == div_q - DIV_W'(1));
  assign tx_pin        = pin_q;
  assign tx_busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    pin_d      = pin_q;
    load_frame = 1'b0;

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          pin_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == last_bit_idx(nbits_q)) begin
            idx_d = 3'd0;
            if (parity_enabled(par_q)) begin
              state_d = PARITY;
              pin_d   = par_bit_q;
            end else begin
              state_d = STOP;
              pin_d   = 1'b1;
            end
          end else begin
            pin_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          pin_d   = 1'b1;
          idx_d   = 3'd0;
        end
      end
      STOP: begin
        // idx counts stop bits here; a queued byte starts with no idle gap.
        if (bit_end) begin
          if (stop2_q && (idx_q == 3'd0)) begin
            idx_d = 3'd1;
          end else if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
            pin_d   = 1'b1;
            idx_d   = 3'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
      end
    endcase

    if (load_frame) begin
      state_d   = START;
      pin_d     = 1'b0;
      cnt_d     = '0;
      idx_d     = 3'd0;
      shreg_d   = fifo_head;
      nbits_d   = data_bits_t'(cfg_data_bits);
      par_d     = parity_t'(cfg_parity);
      stop2_d   = cfg_stop2;
      div_d     = eff_div;
      par_bit_d = (^(fifo_head & data_mask(data_bits_t'(cfg_data_bits))))
                  ^ (parity_t'(cfg_parity) == PAR_ODD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= 3'd0;
      shreg_q   <= 8'h00;
      par_bit_q <= 1'b0;
      nbits_q   <= BITS_5;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      pin_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      nbits_q   <= nbits_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      pin_q     <= pin_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: accepted bytes become predicted frames
// (start cycle plus bit list); a negedge monitor compares the serial line.
module tb_uart_tx_framed;

  localparam int DEPTH   = 16;
  localparam int DEF_DIV = 27 * 1000000 / 115200;

  typedef struct {
    int         start;
    int         div;
    int         nbits;
    int         par;
    int         stop2;
    logic [7:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [15:0] cfg_div;
  logic        tx_pin;
  logic        tx_busy;
  logic [4:0]  fifo_level;

  uart_tx_framed #(
    .CLK_FRE    (27),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .cfg_div       (cfg_div),
    .tx_pin        (tx_pin),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t sb[$];
  int     pend[$];
  int     last_end_m = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     peak_level = 0;

  logic   exp_q[$];
  bit     in_frame = 1'b0;
  bit     idle_bad = 1'b0;
  bit     frame_bad = 1'b0;
  frame_t cur;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Frame as a per-clock list of line levels, derived from the framing rules.
  task automatic expandFrame(input frame_t f);
    logic b[$];
    int   ones;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < f.nbits; i++) begin
      b.push_back(f.data[i]);
      if (f.data[i]) ones++;
    end
    if (f.par == 1) b.push_back((ones % 2) == 1);
    else if (f.par == 2) b.push_back((ones % 2) == 0);
    b.push_back(1'b1);
    if (f.stop2 != 0) b.push_back(1'b1);
    exp_q.delete();
    foreach (b[i]) repeat (f.div) exp_q.push_back(b[i]);
  endtask

  task automatic pushFrame(input logic [7:0] data);
    frame_t f;
    int     bits;
    f.div   = (cfg_div == 16'd0) ? DEF_DIV : int'(cfg_div);
    f.nbits = int'(cfg_data_bits) + 5;
    f.par   = (cfg_parity == 2'b01) ? 1 : (cfg_parity == 2'b10) ? 2 : 0;
    f.stop2 = cfg_stop2 ? 1 : 0;
    f.data  = data;
    f.start = (cyc + 2 > last_end_m) ? cyc + 2 : last_end_m;
    bits    = 1 + f.nbits + ((f.par != 0) ? 1 : 0) + 1 + f.stop2;
    last_end_m = f.start + f.div * bits;
    sb.push_back(f);
    pend.push_back(f.start);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    int   lvl;
    logic rdy;
    @(negedge clk);
    while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
    lvl = pend.size();
    rdy = (lvl < DEPTH);
    if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    checkOutput("tx_data_ready", 32'(tx_data_ready), 32'(rdy));
    checkOutput("fifo_level", 32'(fifo_level), 32'(lvl));
    tx_data       = data;
    tx_data_valid = valid;
    if (valid && rdy) pushFrame(data);
  endtask

  task automatic setCfg(input int bits, input int par, input int stop2, input int div);
    cfg_data_bits = 2'(bits);
    cfg_parity    = 2'(par);
    cfg_stop2     = (stop2 != 0);
    cfg_div       = 16'(div);
  endtask

  task automatic randomCfg();
    setCfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(1, 7));
  endtask

  // Idle until every predicted frame has left the line; optionally disturb
  // the configuration once nothing is left in the FIFO.
  task automatic drain(input bit churn);
    int budget;
    budget = 20000;
    while ((pend.size() > 0 || cyc < last_end_m + 2) && budget > 0) begin
      applyStimulus(1'b0, 8'h00);
      if (churn && pend.size() == 0 && $urandom_range(0, 15) == 0) randomCfg();
      budget--;
    end
    if (pend.size() > 0 || cyc < last_end_m + 2) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain timeout at cycle %0d", cyc);
    end
  endtask

  always @(negedge clk) begin
    logic e;
    if (!rst_n) begin
      sb.delete();
      exp_q.delete();
      in_frame = 1'b0;
      idle_bad = 1'b0;
    end else begin
      if (!in_frame && sb.size() > 0 && sb[0].start == cyc) begin
        cur = sb.pop_front();
        expandFrame(cur);
        in_frame  = 1'b1;
        frame_bad = 1'b0;
        idle_bad  = 1'b0;
      end
      if (in_frame) begin
        e = exp_q.pop_front();
        if (!frame_bad && (tx_pin !== e || tx_busy !== 1'b1)) begin
          frame_bad = 1'b1;
          $display("[TB] FAIL frame 0x%02h cycle %0d: tx_pin=%b tx_busy=%b, required tx_pin=%b tx_busy=1",
                   cur.data, cyc, tx_pin, tx_busy, e);
        end
        if (exp_q.size() == 0) begin
          in_frame = 1'b0;
          vectors++;
          if (frame_bad) miscompares++;
        end
      end else if (!idle_bad && (tx_pin !== 1'b1 || tx_busy !== 1'b0)) begin
        idle_bad = 1'b1;
        vectors++;
        miscompares++;
        $display("[TB] FAIL idle line at cycle %0d: tx_pin=%b tx_busy=%b, required 1 and 0",
                 cyc, tx_pin, tx_busy);
      end
    end
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    setCfg(3, 0, 0, 4);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset tx_pin", 32'(tx_pin), 32'd1);
    checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset tx_data_ready", 32'(tx_data_ready), 32'd1);
    checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00);

    setCfg(3, 0, 0, 234);
    applyStimulus(1'b1, 8'h55);
    drain(1'b0);

    setCfg(2, 1, 1, 4);
    applyStimulus(1'b1, 8'h41);
    drain(1'b0);

    setCfg(0, 2, 0, 4);
    applyStimulus(1'b1, 8'hFF);
    drain(1'b0);

    setCfg(3, 0, 0, 0);
    applyStimulus(1'b1, 8'hA5);
    drain(1'b0);

    setCfg(3, 1, 0, 1);
    applyStimulus(1'b1, 8'h3A);
    applyStimulus(1'b1, 8'hC5);
    applyStimulus(1'b1, 8'h01);
    drain(1'b0);

    setCfg(3, 0, 0, 4);
    peak_level = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("peak fifo_level", 32'(peak_level), 32'd16);
    drain(1'b0);

    setCfg(3, 0, 0, 8);
    applyStimulus(1'b1, 8'h3C);
    repeat (20) applyStimulus(1'b0, 8'h00);
    setCfg(3, 0, 0, 16);
    applyStimulus(1'b1, 8'hC3);
    drain(1'b0);

    for (int t = 0; t < 12; t++) begin
      int n;
      randomCfg();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++)
        applyStimulus($urandom_range(0, 9) < 7, 8'($urandom));
      drain(1'b1);
    end

    setCfg(3, 0, 0, 8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hB0 + 8'(i));
    repeat (14) applyStimulus(1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort tx_pin", 32'(tx_pin), 32'd1);
    checkOutput("abort fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("abort tx_data_ready", 32'(tx_data_ready), 32'd1);
    checkOutput("abort tx_busy", 32'(tx_busy), 32'd0);
    pend.delete();
    last_end_m = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (60) applyStimulus(1'b0, 8'h00);
    checkOutput("post-abort tx_pin", 32'(tx_pin), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
